vec_byte_packer: RTL and testbench
==================================

# vec_byte_packer

Serial-to-vector assembly stage that sits directly upstream of the vector-cons compute stage. It accepts a byte stream over a valid/ready handshake and packs 16 bytes into two 64-bit byte vectors, head byte in the most-significant lane. It presents them as a registered pair on `__out0`/`__out1` with valid/ready, so the downstream stage sees the `__in0`/`__in1` word pair it consumes. Single buffer, no pass-through paths.

## Interface
- `PAD_BYTE`, default 8'h00: fill value for lanes left empty by a flush.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  packer can accept a byte.
- `in_data`  in  8  byte payload.
- `flush`  in  1  pad and emit a partial pair. Present only with `VEC_PACK_FLUSH_EN`.
- `out_valid`  out  1  pair valid.
- `out_ready`  in  1  downstream accepts the pair.
- `__out0`  out  64  vector 0, bytes 0..7 of the pair.
- `__out1`  out  64  vector 1, bytes 8..15 of the pair.

## Operation
- States: FILL and FULL. Internal byte index `idx` is 4 bits, range 0..15.
- FILL:
  - `in_ready`=1 and `out_valid`=0.
  - On the accept condition (`in_valid & in_ready`), byte k = `idx` is written into its lane:
    - k<8: `__out0[63-8k -: 8]`.
    - k≥8: `__out1[63-8(k-8) -: 8]`.
  - Byte 0 therefore lands in `__out0[63:56]` and byte 15 in `__out1[7:0]`.
  - `idx` increments on each accept.
  - An accept at `idx`=15 moves the state to FULL and wraps `idx` to 0.
- FULL:
  - `in_ready`=0 and `out_valid`=1.
  - `__out0`/`__out1` hold stable until `out_ready`=1.
  - On `out_valid & out_ready` the state returns to FILL.
  - Output registers are not cleared; lanes are overwritten as new bytes arrive.
- `in_valid` while in FULL is ignored (no accept). Upstream must hold its data.
- Output data lanes are only meaningful while `out_valid`=1.

## Timing
- Reset values (asynchronous, take effect immediately): state=FILL, `idx`=0, `__out0`=0, `__out1`=0, `out_valid`=0, `in_ready`=1.
- Latency: `out_valid` rises on the edge that accepts byte 15, i.e. it is visible the cycle after the 16th accept.
- `in_ready` falls in that same cycle and rises the cycle after the output handshake.
- Throughput: at most one pair per 17 cycles (16 accept cycles plus 1 output cycle, with `out_ready` held high).
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`. All handshake outputs are registered state decodes.
- Rising edge of `rst` mid-fill or mid-hold discards the partial or pending pair. The first accept after reset is byte 0.

## Configuration
- `VEC_PACK_FLUSH_EN` defined: `flush` port exists. Behaviour in FILL:
  - If an accept occurs in the same cycle, the byte is written first.
  - If the resulting fill count n is 1..15, lanes n..15 are written with `PAD_BYTE`, the state goes to FULL and `idx` goes to 0.
  - If n=16, this is normal completion.
  - If n=0 (no bytes held and no accept), flush is ignored.
  - `flush` in FULL is ignored.
- `VEC_PACK_FLUSH_EN` undefined: `flush` port and padding logic are absent. A pair is emitted only after 16 bytes.

## Test plan
- Reset then stream: bytes 8'h00..8'h0F with `out_ready`=1 -> `out_valid` one cycle after the 16th accept, `__out0`=64'h0001020304050607, `__out1`=64'h08090A0B0C0D0E0F, then `in_ready`=1 the next cycle.
- Backpressure: same stream with `out_ready`=0 for 5 cycles -> outputs stable, `in_ready`=0, and a 17th byte presented is not accepted. Raise `out_ready` -> one handshake, then byte 8'h10 lands in `__out0[63:56]` of the next pair.
- Gapped input: `in_valid` toggled every other cycle, bytes 8'hF0..8'hFF -> `__out0`=64'hF0F1F2F3F4F5F6F7 and `__out1`=64'hF8F9FAFBFCFDFEFF. Only 16 accepts are counted.
- Reset mid-operation: assert `rst` after 5 bytes, then stream 8'hA0..8'hAF -> pair is `__out0`=64'hA0A1A2A3A4A5A6A7, `__out1`=64'hA8A9AAABACADAEAF, with no stale bytes.
- Reset mid-hold: assert `rst` while FULL -> `out_valid`=0, `__out0`=`__out1`=0, `in_ready`=1 immediately.
- Flush (`VEC_PACK_FLUSH_EN`, `PAD_BYTE`=8'hEE):
  - 3 bytes 8'h11,8'h22,8'h33 then `flush` -> `__out0`=64'h112233EEEEEEEEEE, `__out1`=64'hEEEEEEEEEEEEEEEE.
  - `flush` with `idx`=0 and no accept -> no output.
  - `flush` coincident with the 16th byte -> normal pair.

Source files
------------

// File: rtl/vec_byte_packer_if.sv
// Byte-stream in / 128-bit pair out handshake bundle for vec_byte_packer.
// slave: packer side; master: upstream producer plus downstream consumer.
interface vec_byte_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] __out0;
    logic [63:0] __out1;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, __out0, __out1
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, __out0, __out1
    );
endinterface

// File: rtl/vec_byte_packer.sv
// Packs 16 bytes (head byte in MS lane) into a registered 64-bit pair.
// Ports: clk, rst (async high), bus (slave: byte in, pair out, valid/ready),
// flush (only with VEC_PACK_FLUSH_EN: pad remaining lanes with PAD_BYTE).
module vec_byte_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic clk,
    input  logic rst,
`ifdef VEC_PACK_FLUSH_EN
    input  logic flush,
`endif
    vec_byte_packer_if.slave bus
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] data_q, data_d;
    logic         accept;
    logic [6:0]   lane_hi;

`ifdef VEC_PACK_FLUSH_EN
    logic [4:0]   fill_n;
`else
    wire  [7:0]   unused_pad = PAD_BYTE;
`endif

    // Handshake outputs are pure state decodes: no comb input-to-output path.
    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == FULL);
    assign bus.__out0    = data_q[127:64];
    assign bus.__out1    = data_q[63:0];

    assign accept  = bus.in_valid & bus.in_ready;
    // Byte k occupies bits [127-8k -: 8] of the concatenated pair.
    assign lane_hi = 7'd127 - {idx_q, 3'b000};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef VEC_PACK_FLUSH_EN
        fill_n  = {1'b0, idx_q} + {4'b0000, accept};
`endif
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    data_d[lane_hi -: 8] = bus.in_data;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = FULL;
                    end
                end
`ifdef VEC_PACK_FLUSH_EN
                // Partial pair: pad lanes at and beyond the fill count.
                // n==0 has nothing to emit; n==16 is already completion.
                if (flush && fill_n != 5'd0 && fill_n != 5'd16) begin
                    for (int k = 0; k < 16; k++) begin
                        if (5'(k) >= fill_n) begin
                            data_d[(15-k)*8 +: 8] = PAD_BYTE;
                        end
                    end
                    state_d = FULL;
                    idx_d   = 4'd0;
                end
`endif
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= 4'd0;
            data_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_vec_byte_packer.sv
// Directed self-checking bench for vec_byte_packer.
// Covers reset, streaming, backpressure, gaps, resets and optional flush.
module tb_vec_byte_packer;

    logic clk;
    logic rst;
`ifdef VEC_PACK_FLUSH_EN
    logic flush;
`endif
    int   n_cmp;
    int   n_bad;

    vec_byte_packer_if bus ();

    vec_byte_packer #(
        .PAD_BYTE (8'hEE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef VEC_PACK_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, need done)");
        $fatal(1, "watchdog");
    end

    task automatic stream(input logic [7:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 8'(i);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL rst_out_valid got %b need 0", bus.out_valid);
            n_bad++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL rst_in_ready got %b need 1", bus.in_ready);
            n_bad++;
        end
        n_cmp++;
        if (bus.__out0 !== 64'd0 || bus.__out1 !== 64'd0) begin
            $display("FAIL rst_data got %h %h need 0 0", bus.__out0, bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_stream;
        bus.out_ready = 1'b1;
        stream(8'h00, 15);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL stream_early got %b need 0", bus.out_valid);
            n_bad++;
        end
        stream(8'h0F, 1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            $display("FAIL stream_flags got v=%b r=%b need v=1 r=0",
                     bus.out_valid, bus.in_ready);
            n_bad++;
        end
        n_cmp++;
        if (bus.__out0 !== 64'h0001020304050607) begin
            $display("FAIL stream_out0 got %h need 0001020304050607", bus.__out0);
            n_bad++;
        end
        n_cmp++;
        if (bus.__out1 !== 64'h08090A0B0C0D0E0F) begin
            $display("FAIL stream_out1 got %h need 08090a0b0c0d0e0f", bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL stream_after got v=%b r=%b need v=0 r=1",
                     bus.out_valid, bus.in_ready);
            n_bad++;
        end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        stream(8'h00, 16);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.__out0 !== 64'h0001020304050607 ||
                bus.__out1 !== 64'h08090A0B0C0D0E0F) begin
                $display("FAIL bp_hold c=%0d got v=%b r=%b %h %h need v=1 r=0 0001020304050607 08090a0b0c0d0e0f",
                         c, bus.out_valid, bus.in_ready, bus.__out0, bus.__out1);
                n_bad++;
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL bp_release got v=%b r=%b need v=0 r=1",
                     bus.out_valid, bus.in_ready);
            n_bad++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.__out0[63:56] !== 8'h10) begin
            $display("FAIL bp_byte16 got %h need 10", bus.__out0[63:56]);
            n_bad++;
        end
        stream(8'h11, 15);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.__out0 !== 64'h1011121314151617 ||
            bus.__out1 !== 64'h18191A1B1C1D1E1F) begin
            $display("FAIL bp_next got v=%b %h %h need v=1 1011121314151617 18191a1b1c1d1e1f",
                     bus.out_valid, bus.__out0, bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gapped;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hF0 + 8'(i);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_data  = 8'h55;
            if (i < 15) begin
                @(posedge clk);
                #1;
            end
            if (i == 14) begin
                n_cmp++;
                if (bus.out_valid !== 1'b0) begin
                    $display("FAIL gap_count got %b need 0", bus.out_valid);
                    n_bad++;
                end
            end
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.__out0 !== 64'hF0F1F2F3F4F5F6F7 ||
            bus.__out1 !== 64'hF8F9FAFBFCFDFEFF) begin
            $display("FAIL gap_pair got v=%b %h %h need v=1 f0f1f2f3f4f5f6f7 f8f9fafbfcfdfeff",
                     bus.out_valid, bus.__out0, bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_fill;
        bus.out_ready = 1'b1;
        stream(8'h99, 5);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.__out0 !== 64'd0 || bus.out_valid !== 1'b0) begin
            $display("FAIL rfill_clear got v=%b %h need v=0 0", bus.out_valid, bus.__out0);
            n_bad++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        stream(8'hA0, 16);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.__out0 !== 64'hA0A1A2A3A4A5A6A7 ||
            bus.__out1 !== 64'hA8A9AAABACADAEAF) begin
            $display("FAIL rfill_pair got v=%b %h %h need v=1 a0a1a2a3a4a5a6a7 a8a9aaabacadaeaf",
                     bus.out_valid, bus.__out0, bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_hold;
        bus.out_ready = 1'b0;
        stream(8'h30, 16);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL rhold_full got %b need 1", bus.out_valid);
            n_bad++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.__out0 !== 64'd0 || bus.__out1 !== 64'd0) begin
            $display("FAIL rhold_clear got v=%b r=%b %h %h need v=0 r=1 0 0",
                     bus.out_valid, bus.in_ready, bus.__out0, bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
    endtask

`ifdef VEC_PACK_FLUSH_EN
    task automatic test_flush;
        bus.out_ready = 1'b1;
        stream(8'h11, 1);
        stream(8'h22, 1);
        stream(8'h33, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.__out0 !== 64'h112233EEEEEEEEEE ||
            bus.__out1 !== 64'hEEEEEEEEEEEEEEEE) begin
            $display("FAIL flush_pad got v=%b %h %h need v=1 112233eeeeeeeeee eeeeeeeeeeeeeeee",
                     bus.out_valid, bus.__out0, bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("FAIL flush_empty got v=%b r=%b need v=0 r=1",
                     bus.out_valid, bus.in_ready);
            n_bad++;
        end
        stream(8'h40, 15);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h4F;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.__out0 !== 64'h4041424344454647 ||
            bus.__out1 !== 64'h48494A4B4C4D4E4F) begin
            $display("FAIL flush_full got v=%b %h %h need v=1 4041424344454647 48494a4b4c4d4e4f",
                     bus.out_valid, bus.__out0, bus.__out1);
            n_bad++;
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
`ifdef VEC_PACK_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset;
        test_stream;
        test_backpressure;
        test_gapped;
        test_reset_mid_fill;
        test_reset_mid_hold;
`ifdef VEC_PACK_FLUSH_EN
        test_flush;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
